// File: rtl/rbcp_initiator.sv
// rtl/rbcp_initiator.sv - RBCP bus master splitting valid/ready burst commands into per-byte strobes.
// Optional statistics counters are enabled by defining RBCP_INIT_STATS_EN.
module rbcp_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [7:0]  CMD_LEN,
    input  logic        WDAT_VALID,
    output logic        WDAT_READY,
    input  logic [7:0]  WDAT,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_LAST,
    output logic        RSP_ERR,
    output logic        BUSY,
    output logic        RBCP_ACT,
    output logic [31:0] RBCP_ADDR,
    output logic        RBCP_WE,
    output logic [7:0]  RBCP_WD,
    output logic        RBCP_RE,
    input  logic [7:0]  RBCP_RD,
    input  logic        RBCP_ACK,
    input  logic        STAT_CLR,
    output logic [15:0] STAT_BYTES,
    output logic [15:0] STAT_TOUT
);

    localparam logic [16:0] TOUT_LIM = 17'(TIMEOUT_CYCLES);
    localparam logic [3:0]  GAP_INIT = 4'(GAP_CYCLES);
    localparam bit          GAP_NONE = (GAP_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_FETCH,
        S_STROBE,
        S_WAIT_ACK,
        S_GAP,
        S_END
    } state_t;

    state_t      state_q, state_d;
    logic        act_q, act_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic [7:0]  wd_q, wd_d;
    logic        write_q, write_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  gap_q, gap_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_last_q, rsp_last_d;
    logic        rsp_err_q, rsp_err_d;

    logic        launch;
    logic        byte_done;
    logic        tout_hit;

    assign CMD_READY  = (state_q == S_IDLE);
    assign WDAT_READY = (state_q == S_FETCH);
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign RSP_LAST   = rsp_last_q;
    assign RSP_ERR    = rsp_err_q;
    assign BUSY       = busy_q;
    assign RBCP_ACT   = act_q;
    assign RBCP_ADDR  = addr_q;
    assign RBCP_WE    = we_q;
    assign RBCP_WD    = wd_q;
    assign RBCP_RE    = re_q;

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        wd_d        = wd_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 8'h00;
        rsp_last_d  = 1'b0;
        rsp_err_d   = 1'b0;
        launch      = 1'b0;
        byte_done   = 1'b0;
        tout_hit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    addr_d  = CMD_ADDR;
                    write_d = CMD_WRITE;
                    cnt_d   = CMD_LEN;
                    act_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                launch = 1'b1;
            end
            S_FETCH: begin
                if (WDAT_VALID) begin
                    wd_d    = WDAT;
                    we_d    = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_STROBE;
                end
            end
            S_STROBE, S_WAIT_ACK: begin
                // An ACK in the strobe cycle itself counts as arrival at timer 0.
                if (RBCP_ACK) begin
                    byte_done   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = write_q ? 8'h00 : RBCP_RD;
                    rsp_last_d  = (cnt_q == 8'd0);
                    if (cnt_q == 8'd0) begin
                        act_d   = 1'b0;
                        state_d = S_END;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_q + 32'd1;
                        if (GAP_NONE) begin
                            launch = 1'b1;
                        end else begin
                            gap_d   = GAP_INIT - 4'd1;
                            state_d = S_GAP;
                        end
                    end
                end else if ((state_q == S_WAIT_ACK) &&
                             (({1'b0, timer_q} + 17'd1) >= TOUT_LIM)) begin
                    // Error beat lands TIMEOUT_CYCLES cycles after the strobe.
                    tout_hit    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    act_d       = 1'b0;
                    state_d     = S_END;
                end else begin
                    timer_d = timer_q + 16'd1;
                    state_d = S_WAIT_ACK;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    launch = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_END: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Start the next byte: writes fetch data first, reads strobe at once.
        if (launch) begin
            if (write_q) begin
                state_d = S_FETCH;
            end else begin
                re_d    = 1'b1;
                timer_d = 16'd0;
                state_d = S_STROBE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            act_q       <= 1'b0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wd_q        <= 8'h00;
            write_q     <= 1'b0;
            cnt_q       <= 8'd0;
            timer_q     <= 16'd0;
            gap_q       <= 4'd0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            re_q        <= re_d;
            wd_q        <= wd_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef RBCP_INIT_STATS_EN
    logic [15:0] stat_bytes_q, stat_bytes_d;
    logic [15:0] stat_tout_q, stat_tout_d;

    // A clear wins over a coincident increment; counters saturate.
    always_comb begin
        stat_bytes_d = stat_bytes_q;
        stat_tout_d  = stat_tout_q;
        if (STAT_CLR) begin
            stat_bytes_d = 16'd0;
            stat_tout_d  = 16'd0;
        end else begin
            if (byte_done && (stat_bytes_q != 16'hFFFF)) begin
                stat_bytes_d = stat_bytes_q + 16'd1;
            end
            if (tout_hit && (stat_tout_q != 16'hFFFF)) begin
                stat_tout_d = stat_tout_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_bytes_q <= 16'd0;
            stat_tout_q  <= 16'd0;
        end else begin
            stat_bytes_q <= stat_bytes_d;
            stat_tout_q  <= stat_tout_d;
        end
    end

    assign STAT_BYTES = stat_bytes_q;
    assign STAT_TOUT  = stat_tout_q;
`else
    logic unused_stats;
    assign unused_stats = STAT_CLR ^ byte_done ^ tout_hit;
    assign STAT_BYTES   = 16'd0;
    assign STAT_TOUT    = 16'd0;
`endif

endmodule
